rx_cmd_decoder: RTL

//  Consumes the byte stream delivered into the system clock domain by the data synchronizer.

---
 rtl/rx_cmd_decoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rx_cmd_decoder.sv
// rtl/rx_cmd_decoder.sv - command frame parser driving register-file accesses and read-data return
// Frames: {WR_CMD, addr, data} writes, {RD_CMD, addr} reads and returns data on the tx handshake.
module rx_cmd_decoder #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
  parameter int                    RD_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  output logic                  cmd_err,
  output logic                  rx_overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_WAIT = 3'd5
  } state_t;

  localparam int              CW      = $clog2(RD_TIMEOUT + 1);
  // Last counter value still inside the wait window; the cycle spent there is the final one allowed.
  localparam logic [CW-1:0]   TO_LAST = CW'(RD_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    err_q, err_d;
  logic                    ovr_q, ovr_d;
  logic                    addr_bad;

  assign addr_bad = (rx_data[DATA_WIDTH-1:ADDR_WIDTH] != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    ovr_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == WR_CMD)      state_d = WR_ADDR;
          else if (rx_data == RD_CMD) state_d = RD_ADDR;
          else                        err_d   = 1'b1;
        end
      end
      WR_ADDR, RD_ADDR: begin
        if (rx_valid) begin
          if (addr_bad) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d = rx_data[ADDR_WIDTH-1:0];
            if (state_q == WR_ADDR) begin
              state_d = WR_DATA;
            end else begin
              rd_en_d = 1'b1;
              state_d = RD_WAIT;
            end
          end
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          wr_data_d = rx_data;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_WAIT: begin
        ovr_d = rx_valid;
        // Read data arriving on the last allowed cycle wins over the timeout.
        if (rf_rd_valid) begin
          tx_data_d  = rf_rd_data;
          tx_valid_d = 1'b1;
          state_d    = TX_WAIT;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_WAIT: begin
        ovr_d = rx_valid;
        if (!tx_busy) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rf_addr    = addr_q;
  assign rf_wr_data = wr_data_q;
  assign rf_wr_en   = wr_en_q;
  assign rf_rd_en   = rd_en_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign cmd_err    = err_q;
  assign rx_overrun = ovr_q;

endmodule
